// File: rtl/fir_coef_loader_if.sv
// Coefficient memory bus between the loader and its ROM/RAM.
// The master side drives ROM reads and RAM writes; the slave side returns ROM data.
interface fir_coef_loader_if #(
  parameter int AW = 7,
  parameter int DW = 16,
  parameter int BW = 2
);
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_bank;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;

  modport master (
    output rom_addr, rom_rd, ram_addr, ram_bank, ram_wdata, ram_we,
    input  rom_data
  );

  modport slave (
    input  rom_addr, rom_rd, ram_addr, ram_bank, ram_wdata, ram_we,
    output rom_data
  );
endinterface

// File: rtl/fir_coef_loader.sv
// Copies len coefficients from ROM into one RAM bank, one tap every four cycles.
// Optional running checksum of written coefficients under FIR_COEF_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | present ROM address k
// READ  | ROM read strobe for tap k
// WRITE | ROM data valid, write it to RAM[bank_q][k]
// NEXT  | advance k or finish
// DONE  | one-cycle completion pulse
module fir_coef_loader #(
  parameter int NTAPS = 64,
  parameter int AW    = 7,
  parameter int DW    = 16,
  parameter int BW    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [AW:0]         len,
  input  logic [BW-1:0]       bank_sel,
  fir_coef_loader_if.master   mem,
  output logic                busy,
  output logic                done,
  output logic [DW+AW-1:0]    checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  logic [AW-1:0] k;
  logic [AW-1:0] len_q;
  logic [BW-1:0] bank_q;
  logic [AW-1:0] rom_addr_q;
  logic          rom_rd_q;
  logic [AW-1:0] ram_addr_q;
  logic          ram_we_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      len_q      <= '0;
      bank_q     <= '0;
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= ADDR;
              k      <= '0;
              bank_q <= bank_sel;
              len_q  <= (len > (AW+1)'(NTAPS)) ? AW'(NTAPS) : len[AW-1:0];
            end
          end
        end
        ADDR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= READ;
            rom_addr_q <= k;
            rom_rd_q   <= 1'b1;
          end
        end
        READ: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= WRITE;
            ram_addr_q <= k;
            ram_we_q   <= 1'b1;
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (k == len_q - AW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= ADDR;
            k          <= k + AW'(1);
            rom_addr_q <= k + AW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.rom_addr  = rom_addr_q;
  assign mem.rom_rd    = rom_rd_q;
  assign mem.ram_addr  = ram_addr_q;
  assign mem.ram_we    = ram_we_q;
  assign mem.ram_bank  = bank_q;
  // ROM data only arrives during WRITE, so write data is gated rather than registered
  assign mem.ram_wdata = ram_we_q ? mem.rom_data : '0;

`ifdef FIR_COEF_CHECKSUM_EN
  logic [DW+AW-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (state == IDLE && start) begin
      csum_q <= '0;
    end else if (state == WRITE) begin
      csum_q <= csum_q + {{AW{mem.rom_data[DW-1]}}, mem.rom_data};
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with a behavioural ROM and a RAM write logger.
// Expected checksums follow FIR_COEF_CHECKSUM_EN as defined for the build.
module tb_fir_coef_loader;
  localparam int NTAPS = 64;
  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int BW    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [AW:0]       len = '0;
  logic [BW-1:0]     bank_sel = '0;
  logic              busy;
  logic              done;
  logic [DW+AW-1:0]  checksum;

  fir_coef_loader_if #(.AW(AW), .DW(DW), .BW(BW)) bus ();

  fir_coef_loader #(.NTAPS(NTAPS), .AW(AW), .DW(DW), .BW(BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .len      (len),
    .bank_sel (bank_sel),
    .mem      (bus.master),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_mem [0:127];
  always @(posedge clk) if (bus.rom_rd) bus.rom_data <= rom_mem[bus.rom_addr];

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int            s0;
  int            nw, ndone, nrd, done_cyc, last_we;
  logic [AW-1:0] wr_addr [0:127];
  logic [DW-1:0] wr_data [0:127];
  logic [BW-1:0] wr_bank [0:127];

  always @(negedge clk) begin
    if (bus.ram_we) begin
      if (nw < 128) begin
        wr_addr[nw] = bus.ram_addr;
        wr_data[nw] = bus.ram_wdata;
        wr_bank[nw] = bus.ram_bank;
      end
      nw      = nw + 1;
      last_we = edges - s0;
    end
    if (done) begin
      ndone    = ndone + 1;
      done_cyc = edges - s0;
    end
    if (bus.rom_rd) nrd = nrd + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic do_start(input logic [AW:0] l, input logic [BW-1:0] b);
    @(negedge clk);
    nw = 0; ndone = 0; nrd = 0; done_cyc = 0; last_we = 0;
    start = 1'b1; len = l; bank_sel = b;
    s0 = edges;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("timeout", 64'(busy), 64'd0);
  endtask

  function automatic logic [DW+AW-1:0] exp_csum(input int n);
    logic [DW+AW-1:0] acc;
    acc = '0;
`ifdef FIR_COEF_CHECKSUM_EN
    for (int i = 0; i < n; i++) acc = acc + {{AW{rom_mem[i][DW-1]}}, rom_mem[i]};
`endif
    return acc;
  endfunction

  initial begin
    int seq_err;
    for (int i = 0; i < 128; i++) rom_mem[i] = DW'(i * 3 - 50);
    nw = 0; ndone = 0; nrd = 0; done_cyc = 0; last_we = 0; s0 = 0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ctl", {60'd0, busy, done, bus.rom_rd, bus.ram_we}, 64'd0);
    check("rst_addr", {bus.rom_addr, bus.ram_addr, bus.ram_bank}, 64'd0);
    check("rst_wdata", 64'(bus.ram_wdata), 64'd0);
    check("rst_csum", 64'(checksum), 64'd0);
    reset = 1'b0;

    // len=3 into bank 2
    rom_mem[0] = 16'sd5; rom_mem[1] = -16'sd2; rom_mem[2] = 16'sd7;
    do_start(8'd3, 2'd2);
    wait_idle(40);
    check("s1_nw", 64'(nw), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("s1_addr", 64'(wr_addr[i]), 64'(i));
      check("s1_bank", 64'(wr_bank[i]), 64'd2);
    end
    check("s1_d0", 64'(wr_data[0]), 64'h0005);
    check("s1_d1", 64'(wr_data[1]), 64'hFFFE);
    check("s1_d2", 64'(wr_data[2]), 64'h0007);
    check("s1_last_we", 64'(last_we), 64'd11);
    check("s1_done_cyc", 64'(done_cyc), 64'd13);
    check("s1_ndone", 64'(ndone), 64'd1);
`ifdef FIR_COEF_CHECKSUM_EN
    check("s1_csum", 64'(checksum), 64'd10);
`else
    check("s1_csum", 64'(checksum), 64'd0);
`endif
    check("s1_bank_hold", 64'(bus.ram_bank), 64'd2);

    // len=0: immediate done, no memory traffic
    do_start(8'd0, 2'd1);
    wait_idle(10);
    check("s2_done_cyc", 64'(done_cyc), 64'd1);
    check("s2_ndone", 64'(ndone), 64'd1);
    check("s2_nw", 64'(nw), 64'd0);
    check("s2_nrd", 64'(nrd), 64'd0);

    // len=100 clamps to 64
    for (int i = 0; i < 128; i++) rom_mem[i] = DW'(i * 3 - 50);
    do_start(8'd100, 2'd3);
    wait_idle(400);
    check("s3_nw", 64'(nw), 64'd64);
    seq_err = 0;
    for (int i = 0; i < 64; i++)
      if (wr_addr[i] != AW'(i) || wr_data[i] != DW'(i * 3 - 50) || wr_bank[i] != 2'd3) seq_err++;
    check("s3_seq", 64'(seq_err), 64'd0);
    check("s3_done_cyc", 64'(done_cyc), 64'd257);
    check("s3_nrd", 64'(nrd), 64'd64);
    check("s3_csum", 64'(checksum), 64'(exp_csum(64)));

    // start pulsed mid-load is ignored
    do_start(8'd4, 2'd1);
    repeat (3) @(negedge clk);
    start = 1'b1; len = 8'd2; bank_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(40);
    check("s4_nw", 64'(nw), 64'd4);
    check("s4_ndone", 64'(ndone), 64'd1);
    check("s4_done_cyc", 64'(done_cyc), 64'd17);
    check("s4_bank", 64'(wr_bank[3]), 64'd1);

    // abort in cycle 6 (READ of tap 1)
    do_start(8'd4, 2'd2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s5_busy", 64'(busy), 64'd0);
    check("s5_we", 64'(bus.ram_we), 64'd0);
    repeat (3) @(negedge clk);
    check("s5_nw", 64'(nw), 64'd1);
    check("s5_addr", 64'(wr_addr[0]), 64'd0);
    check("s5_ndone", 64'(ndone), 64'd0);
    // restart, with abort high across the accepting edge (ignored in IDLE)
    abort = 1'b1;
    do_start(8'd2, 2'd1);
    abort = 1'b0;
    wait_idle(40);
    check("s5_re_nw", 64'(nw), 64'd2);
    check("s5_re_done", 64'(done_cyc), 64'd9);
    check("s5_re_ndone", 64'(ndone), 64'd1);

    // reset during WRITE of tap 2 (cycle 11)
    do_start(8'd5, 2'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("s6_ctl", {60'd0, busy, done, bus.rom_rd, bus.ram_we}, 64'd0);
    check("s6_addr", {bus.rom_addr, bus.ram_addr, bus.ram_bank}, 64'd0);
    check("s6_wdata", 64'(bus.ram_wdata), 64'd0);
    check("s6_csum", 64'(checksum), 64'd0);
    check("s6_nw", 64'(nw), 64'd3);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("s6_ndone", 64'(ndone), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 The module SHALL have parameter NTAPS, default 64, meaning maximum taps per bank.
REQ-002 The module SHALL have parameter AW, default 7, meaning the address width; it SHALL satisfy 2^AW > NTAPS.
REQ-003 The module SHALL have parameter DW, default 16, meaning the coefficient width (signed).
REQ-004 The module SHALL have parameter BW, default 2, meaning the bank-select width; there SHALL be 2^BW banks.
REQ-005 Port clk  in  1  SHALL be the clock.
REQ-006 Port reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-007 Port start  in  1  SHALL be a load request, sampled only in IDLE.
REQ-008 Port abort  in  1  SHALL cancel an active load.
REQ-009 Port len  in  AW+1  SHALL give the tap count, sampled with start.
REQ-010 Port bank_sel  in  BW  SHALL give the destination bank, sampled with start.
REQ-011 Port rom_addr  out  AW  SHALL be the coefficient ROM address.
REQ-012 Port rom_rd  out  1  SHALL be the ROM read strobe; data is valid on the next cycle.
REQ-013 Port rom_data  in  DW  SHALL be the ROM read data.
REQ-014 Port ram_addr  out  AW  SHALL be the coefficient RAM address.
REQ-015 Port ram_bank  out  BW  SHALL be the RAM bank select.
REQ-016 Port ram_wdata  out  DW  SHALL be the RAM write data.
REQ-017 Port ram_we  out  1  SHALL be the RAM write enable.
REQ-018 Port busy  out  1  SHALL be high in every state except IDLE.
REQ-019 Port done  out  1  SHALL be a one-cycle completion pulse.
REQ-020 Port checksum  out  DW+AW  SHALL be the signed sum of the written coefficients.

Function
REQ-021 The FSM SHALL implement states IDLE, ADDR, READ, WRITE, NEXT and DONE.
REQ-022 The FSM SHALL go from IDLE to ADDR when start=1 and len>0, latching len_q, bank_q and k=0.
REQ-023 The FSM SHALL go from IDLE directly to DONE when start=1 and len=0, with no ROM or RAM access.
REQ-024 The FSM SHALL follow ADDR->READ->WRITE->NEXT, one cycle each.
REQ-025 In NEXT, the FSM SHALL go to DONE if k==len_q-1; otherwise it SHALL increment k and go to ADDR.
REQ-026 The FSM SHALL go from DONE to IDLE unconditionally.
REQ-027 rom_addr SHALL equal k in ADDR and READ, and 0 otherwise.
REQ-028 rom_rd SHALL be 1 only in READ.
REQ-029 In WRITE, ram_we SHALL be 1, ram_addr SHALL equal k, ram_wdata SHALL equal rom_data and ram_bank SHALL equal bank_q.
REQ-030 Outside WRITE, ram_we, ram_addr and ram_wdata SHALL be 0, and ram_bank SHALL hold bank_q.
REQ-031 done SHALL be 1 only in DONE.
REQ-032 For start accepted at edge 0 with len=L>0, the last ram_we SHALL occur in cycle 4L-1 and done SHALL occur in cycle 4L+1.
REQ-033 A len value greater than NTAPS SHALL be clamped to NTAPS at capture.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 abort=1 in ADDR, READ, WRITE or NEXT SHALL force IDLE on the next edge with no done pulse and ram_we=0 in that cycle; abort SHALL have priority over all other transitions.
REQ-036 abort SHALL be ignored in IDLE and DONE.

Reset
REQ-037 reset=1 SHALL force IDLE on the next edge, with k=0, len_q=0, bank_q=0 and checksum=0, from any state including mid-load.
REQ-038 While in reset, all outputs SHALL be 0.
REQ-039 reset SHALL have priority over abort and start.

Configuration
REQ-040 With macro FIR_COEF_CHECKSUM_EN defined, checksum SHALL clear to 0 when start is accepted and, in each WRITE, SHALL add the sign-extended rom_data with wrap-around modulo 2^(DW+AW).
REQ-041 With FIR_COEF_CHECKSUM_EN defined, checksum SHALL hold its value after DONE until the next accepted start or reset.
REQ-042 Without FIR_COEF_CHECKSUM_EN, checksum SHALL be tied to 0 and no accumulator SHALL be synthesised.

Verification
REQ-043 Scenario: len=3, bank_sel=2, ROM[0..2]=5,-2,7 -> writes to (bank 2, addr 0..2) with 5,-2,7; done at cycle 13; checksum=10 (macro on) or 0 (macro off).
REQ-044 Scenario: len=0 with start -> done at cycle 1; rom_rd and ram_we never asserted.
REQ-045 Scenario: len=100 with NTAPS=64 -> exactly 64 writes to addr 0..63; done at cycle 257.
REQ-046 Scenario: start pulsed during a len=4 load -> ignored; exactly 4 writes; a single done.
REQ-047 Scenario: abort in cycle 6 of a len=4 load -> only addr 0 written; IDLE at cycle 7; no done; a subsequent start runs normally.
REQ-048 Scenario: reset asserted in WRITE of tap 2 -> ram_we=0 from the next cycle; all outputs 0; busy=0.
